// File: rtl/cache_set_controller_if.sv
// CPU, set-bank and memory signals seen by the cache set controller.
// master is the controller side; slave is the CPU / set bank / memory side.
interface cache_set_controller_if #(
  parameter int TAG_WIDTH  = 24,
  parameter int SET_WIDTH  = 4,
  parameter int LINE_WIDTH = 2
);
  logic                  cpu_valid;
  logic                  cpu_ready;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic                  cpu_rvalid;
  logic [31:0]           cpu_rdata;

  logic                  set_en;
  logic [SET_WIDTH-1:0]  set_sel;
  logic [1:0]            set_mode;
  logic                  set_tick_en;
  logic [31:0]           set_now;
  logic [TAG_WIDTH-1:0]  set_target;
  logic [LINE_WIDTH-1:0] set_index;
  logic [31:0]           set_data;
  logic                  set_hit;
  logic [31:0]           set_out;
  logic                  set_dirty;
  logic [TAG_WIDTH-1:0]  set_tag;

  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rvalid, cpu_rdata,
    output set_en, set_sel, set_mode, set_tick_en, set_now, set_target, set_index, set_data,
    input  set_hit, set_out, set_dirty, set_tag,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata,
    input  set_en, set_sel, set_mode, set_tick_en, set_now, set_target, set_index, set_data,
    output set_hit, set_out, set_dirty, set_tag,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_set_controller.sv
// Lookup / victim / write-back / refill sequencer for one CPU port over a bank of cache sets.
// All outputs are registered; hit completes 2 cycles after accept, cpu_ready is low outside IDLE.
module cache_set_controller #(
  parameter int TAG_WIDTH  = 24,
  parameter int SET_WIDTH  = 4,
  parameter int LINE_WIDTH = 2
) (
  input logic                    clk,
  input logic                    reset,
  cache_set_controller_if.master bus
);
  localparam int SOFF = LINE_WIDTH + 2;
  localparam int TOFF = SET_WIDTH + LINE_WIDTH + 2;
  localparam logic [1:0] MODE_READ  = 2'b10;
  localparam logic [1:0] MODE_WRITE = 2'b11;
  localparam logic [1:0] MODE_REQ   = 2'b00;
  localparam logic [1:0] MODE_ALLOC = 2'b01;
  localparam logic [LINE_WIDTH-1:0] LAST_WORD = '1;
  localparam logic [LINE_WIDTH-1:0] ONE_WORD  = 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, VICTIM, WB, FILL, REPLAY} state_t;

  state_t                state_q, state_d;
  logic                  req_we_q, req_we_d;
  logic [31:0]           req_addr_q, req_addr_d;
  logic [31:0]           req_wdata_q, req_wdata_d;
  logic [TAG_WIDTH-1:0]  vtag_q, vtag_d;
  logic [LINE_WIDTH-1:0] cnt_q, cnt_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic [31:0]           cpu_rdata_q, cpu_rdata_d;
  logic                  set_en_q, set_en_d;
  logic [SET_WIDTH-1:0]  set_sel_q, set_sel_d;
  logic [1:0]            set_mode_q, set_mode_d;
  logic                  set_tick_en_q, set_tick_en_d;
  logic [31:0]           set_now_q, set_now_d;
  logic [TAG_WIDTH-1:0]  set_target_q, set_target_d;
  logic [LINE_WIDTH-1:0] set_index_q, set_index_d;
  logic [31:0]           set_data_q, set_data_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic [TAG_WIDTH-1:0]  req_tag;
  logic [SET_WIDTH-1:0]  req_set;
  logic [LINE_WIDTH-1:0] req_word;
  logic                  unused_byte_offset;

  assign req_tag            = req_addr_q[31:TOFF];
  assign req_set            = req_addr_q[TOFF-1:SOFF];
  assign req_word           = req_addr_q[SOFF-1:2];
  assign unused_byte_offset = ^{bus.cpu_addr[1:0], req_addr_q[1:0]};

  always_comb begin
    state_d       = state_q;
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    vtag_d        = vtag_q;
    cnt_d         = cnt_q;
    cpu_ready_d   = cpu_ready_q;
    cpu_rvalid_d  = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    set_en_d      = 1'b0;
    set_sel_d     = set_sel_q;
    set_mode_d    = set_mode_q;
    set_tick_en_d = 1'b0;
    set_now_d     = set_now_q;
    set_target_d  = set_target_q;
    set_index_d   = set_index_q;
    set_data_d    = set_data_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_valid) begin
          req_we_d     = bus.cpu_we;
          req_addr_d   = bus.cpu_addr;
          req_wdata_d  = bus.cpu_wdata;
          cpu_ready_d  = 1'b0;
          set_now_d    = set_now_q + 32'd1;
          set_mode_d   = MODE_READ;
          set_sel_d    = bus.cpu_addr[TOFF-1:SOFF];
          set_target_d = bus.cpu_addr[31:TOFF];
          set_index_d  = bus.cpu_addr[SOFF-1:2];
          state_d      = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.set_hit) begin
          set_tick_en_d = 1'b1;
          cpu_rvalid_d  = 1'b1;
          cpu_ready_d   = 1'b1;
          state_d       = IDLE;
          if (req_we_q) begin
            set_mode_d = MODE_WRITE;
            set_en_d   = 1'b1;
            set_data_d = req_wdata_q;
          end else begin
            cpu_rdata_d = bus.set_out;
          end
        end else begin
          set_mode_d = MODE_REQ;
          state_d    = VICTIM;
        end
      end
      VICTIM: begin
        vtag_d      = bus.set_tag;
        cnt_d       = '0;
        set_index_d = '0;
        if (bus.set_dirty) begin
          // Victim words are read back through the normal read path, addressed by its own tag.
          set_mode_d   = MODE_READ;
          set_target_d = bus.set_tag;
          state_d      = WB;
        end else begin
          mem_we_d = 1'b0;
          state_d  = FILL;
        end
      end
      WB: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {vtag_q, req_set, cnt_q, 2'b00};
          mem_wdata_d = bus.set_out;
        end else if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          cnt_d       = cnt_q + ONE_WORD;
          set_index_d = cnt_q + ONE_WORD;
          if (cnt_q == LAST_WORD) begin
            mem_we_d = 1'b0;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_set, cnt_q, 2'b00};
        end else if (bus.mem_ack) begin
          mem_req_d     = 1'b0;
          set_mode_d    = MODE_ALLOC;
          set_en_d      = 1'b1;
          set_tick_en_d = 1'b1;
          set_data_d    = bus.mem_rdata;
          set_index_d   = cnt_q;
          set_target_d  = req_tag;
          cnt_d         = cnt_q + ONE_WORD;
          if (cnt_q == LAST_WORD) state_d = REPLAY;
        end
      end
      REPLAY: begin
        // The last alloc write lands this cycle; the read for the replayed lookup follows it.
        set_mode_d   = MODE_READ;
        set_target_d = req_tag;
        set_index_d  = req_word;
        state_d      = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      vtag_q        <= '0;
      cnt_q         <= '0;
      cpu_ready_q   <= 1'b1;
      cpu_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      set_en_q      <= 1'b0;
      set_sel_q     <= '0;
      set_mode_q    <= '0;
      set_tick_en_q <= 1'b0;
      set_now_q     <= '0;
      set_target_q  <= '0;
      set_index_q   <= '0;
      set_data_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      req_we_q      <= req_we_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      vtag_q        <= vtag_d;
      cnt_q         <= cnt_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      set_en_q      <= set_en_d;
      set_sel_q     <= set_sel_d;
      set_mode_q    <= set_mode_d;
      set_tick_en_q <= set_tick_en_d;
      set_now_q     <= set_now_d;
      set_target_q  <= set_target_d;
      set_index_q   <= set_index_d;
      set_data_q    <= set_data_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.cpu_ready   = cpu_ready_q;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.set_en      = set_en_q;
  assign bus.set_sel     = set_sel_q;
  assign bus.set_mode    = set_mode_q;
  assign bus.set_tick_en = set_tick_en_q;
  assign bus.set_now     = set_now_q;
  assign bus.set_target  = set_target_q;
  assign bus.set_index   = set_index_q;
  assign bus.set_data    = set_data_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_cache_set_controller.sv
// Directed bench: one-line-per-set bank model, word memory with variable ack delay, transaction log.
module tb_cache_set_controller;
  localparam int TW = 24;
  localparam int SW = 4;
  localparam int LW = 2;
  localparam int NSETS = 16;
  localparam int NWORDS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_set_controller_if #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .LINE_WIDTH(LW)) bus ();

  cache_set_controller #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .LINE_WIDTH(LW)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Set bank: one line per set, shares the controller reset.
  logic [TW-1:0] b_tag   [NSETS];
  logic          b_vld   [NSETS];
  logic          b_dirty [NSETS];
  logic [31:0]   b_data  [NSETS][NWORDS];

  assign bus.set_hit   = b_vld[bus.set_sel] && (b_tag[bus.set_sel] == bus.set_target);
  assign bus.set_out   = b_data[bus.set_sel][bus.set_index];
  assign bus.set_dirty = b_vld[bus.set_sel] && b_dirty[bus.set_sel];
  assign bus.set_tag   = b_tag[bus.set_sel];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSETS; s++) begin
        b_vld[s]   <= 1'b0;
        b_dirty[s] <= 1'b0;
        b_tag[s]   <= '0;
        for (int w = 0; w < NWORDS; w++) b_data[s][w] <= '0;
      end
    end else if (bus.set_en) begin
      b_data[bus.set_sel][bus.set_index] <= bus.set_data;
      if (bus.set_mode == 2'b11) begin
        b_dirty[bus.set_sel] <= 1'b1;
      end else if (bus.set_mode == 2'b01) begin
        b_tag[bus.set_sel]   <= bus.set_target;
        b_vld[bus.set_sel]   <= 1'b1;
        b_dirty[bus.set_sel] <= 1'b0;
      end
    end
  end

  // Memory responder and transaction log.
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic [31:0] mem [logic [29:0]];
  txn_t log_q[$];
  txn_t exp_q[$];
  int   base_dly = 1;
  bit   rand_dly = 1'b0;
  bit   spur     = 1'b0;

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    bit          we;
    bit          live;
    int          d;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (spur) begin
        bus.mem_rdata = 32'hBAD0_BAD0;
        bus.mem_ack   = 1'b1;
        spur          = 1'b0;
      end else if (bus.mem_req) begin
        a    = bus.mem_addr;
        wd   = bus.mem_wdata;
        we   = bus.mem_we;
        d    = rand_dly ? int'($urandom_range(5, 0)) : base_dly;
        live = 1'b1;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (!bus.mem_req) begin
            live = 1'b0;
            break;
          end
          check("mem_addr_stable", bus.mem_addr, a);
          check("mem_wdata_stable", bus.mem_wdata, wd);
        end
        if (live) begin
          if (we) begin
            mem[a[31:2]] = wd;
            log_q.push_back('{1'b1, a, wd});
          end else begin
            bus.mem_rdata = mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
            log_q.push_back('{1'b0, a, bus.mem_rdata});
          end
          bus.mem_ack = 1'b1;
        end
      end
    end
  end

  task automatic exp_txn(input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{we, a, d});
  endtask

  task automatic check_log(input string tag);
    check({tag, "_txn_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tag, "_txn_we"}, {31'd0, log_q[i].we}, {31'd0, exp_q[i].we});
      check({tag, "_txn_addr"}, log_q[i].addr, exp_q[i].addr);
      check({tag, "_txn_data"}, log_q[i].data, exp_q[i].data);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic cpu_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    bit seen;
    seen = 1'b0;
    rd   = '0;
    @(negedge clk);
    check("cpu_ready_idle", {31'd0, bus.cpu_ready}, 32'd1);
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    @(posedge clk);
    lat = 0;
    while (!seen && lat < 400) begin
      @(negedge clk);
      bus.cpu_valid = 1'b0;
      lat++;
      if (bus.cpu_rvalid) begin
        seen = 1'b1;
        rd   = bus.cpu_rdata;
      end
    end
    check("cpu_rvalid_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("cpu_rvalid_pulse", {31'd0, bus.cpu_rvalid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"}, {31'd0, bus.cpu_ready}, 32'd1);
    check({tag, "_cpu_rvalid"}, {31'd0, bus.cpu_rvalid}, 32'd0);
    check({tag, "_set_en"}, {31'd0, bus.set_en}, 32'd0);
    check({tag, "_set_tick_en"}, {31'd0, bus.set_tick_en}, 32'd0);
    check({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    check({tag, "_set_now"}, bus.set_now, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_set_mode"}, {30'd0, bus.set_mode}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    bit          reached;
    rst_n         = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      mem[30'h400 + 30'(i)] = 32'hA0 + i;
      mem[30'h800 + 30'(i)] = 32'hB0 + i;
      mem[30'hC00 + 30'(i)] = 32'hC0 + i;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Cold load: four fill reads then the requested word.
    cpu_op(1'b0, 32'h0000_1004, 32'h0, rd, lat);
    check("t1_rdata", rd, 32'hA1);
    for (int i = 0; i < 4; i++) exp_txn(1'b0, 32'h1000 + 4 * i, 32'hA0 + i);
    check_log("t1");

    // Same load again hits.
    cpu_op(1'b0, 32'h0000_1004, 32'h0, rd, lat);
    check("t2_rdata", rd, 32'hA1);
    check("t2_hit_latency", lat, 32'd2);
    check("t2_set_now", bus.set_now, 32'd2);
    check_log("t2");

    // Store hit then load back.
    cpu_op(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, rd, lat);
    check("t3_store_latency", lat, 32'd2);
    cpu_op(1'b0, 32'h0000_1008, 32'h0, rd, lat);
    check("t3_rdata", rd, 32'hDEAD_BEEF);
    check("t3_set_now", bus.set_now, 32'd4);
    check_log("t3");

    // Conflicting tag in set 0 evicts the dirty line first.
    cpu_op(1'b0, 32'h0000_2004, 32'h0, rd, lat);
    check("t4_rdata", rd, 32'hB1);
    exp_txn(1'b1, 32'h1000, 32'hA0);
    exp_txn(1'b1, 32'h1004, 32'hA1);
    exp_txn(1'b1, 32'h1008, 32'hDEAD_BEEF);
    exp_txn(1'b1, 32'h100C, 32'hA3);
    for (int i = 0; i < 4; i++) exp_txn(1'b0, 32'h2000 + 4 * i, 32'hB0 + i);
    check_log("t4");

    // Reset while the second fill word is outstanding.
    base_dly = 2;
    @(negedge clk);
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0000_3000;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (log_q.size() == 1 && bus.mem_req && !bus.mem_ack) reached = 1'b1;
      else @(negedge clk);
    end
    check("t5_second_fill_reached", {31'd0, reached}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t5_abort");
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    cpu_op(1'b0, 32'h0000_3004, 32'h0, rd, lat);
    check("t5_rdata", rd, 32'hC1);
    check("t5_set_now", bus.set_now, 32'd1);
    for (int i = 0; i < 4; i++) exp_txn(1'b0, 32'h3000 + 4 * i, 32'hC0 + i);
    check_log("t5");

    // Spurious ack in IDLE, then random ack delays across write-back and fill.
    @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_spur_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("t6_spur_cpu_ready", {31'd0, bus.cpu_ready}, 32'd1);
    check("t6_spur_set_en", {31'd0, bus.set_en}, 32'd0);
    check("t6_spur_set_now", bus.set_now, 32'd1);
    rand_dly = 1'b1;
    cpu_op(1'b1, 32'h0000_3000, 32'h5EED_0001, rd, lat);
    check("t6_store_latency", lat, 32'd2);
    cpu_op(1'b0, 32'h0000_1008, 32'h0, rd, lat);
    check("t6_rdata", rd, 32'hDEAD_BEEF);
    exp_txn(1'b1, 32'h3000, 32'h5EED_0001);
    exp_txn(1'b1, 32'h3004, 32'hC1);
    exp_txn(1'b1, 32'h3008, 32'hC2);
    exp_txn(1'b1, 32'h300C, 32'hC3);
    exp_txn(1'b0, 32'h1000, 32'hA0);
    exp_txn(1'b0, 32'h1004, 32'hA1);
    exp_txn(1'b0, 32'h1008, 32'hDEAD_BEEF);
    exp_txn(1'b0, 32'h100C, 32'hA3);
    check_log("t6");
    cpu_op(1'b0, 32'h0000_100C, 32'h0, rd, lat);
    check("t6_hit_rdata", rd, 32'hA3);
    check("t6_hit_latency", lat, 32'd2);
    check_log("t6_hit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
